matrix_io_seq: RTL and testbench

Parametrised operand-entry and result-display sequencer for the systolic-array board design. It assembles bit-serial button input into `width_p`-bit operands and hands each operand downstream on a valid/ready port. It then collects `num_results_p` result words on a valid/yumi port and shows each result on the display bus for a fixed dwell time. It replaces the hard-coded SIPO, entry counter, FIFO and slow-clock glue with one block that supports any operand count, result count, width and dwell time.

---
 rtl/matrix_io_seq.sv | 138 +++++++++++++
 tb/tb_matrix_io_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_io_seq.sv
// Operand-entry and result-display sequencer: bit-serial operand assembly,
// valid/ready operand hand-off, result collection and timed display.
module matrix_io_seq #(
    parameter int width_p        = 8,
    parameter int num_entries_p  = 4,
    parameter int num_results_p  = 4,
    parameter int dwell_cycles_p = 60000000
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   bit_valid_i,
    input  logic                                   bit_i,
    output logic                                   op_valid_o,
    output logic [width_p-1:0]                     op_data_o,
    input  logic                                   op_ready_i,
    input  logic                                   res_valid_i,
    input  logic [width_p-1:0]                     res_data_i,
    output logic                                   res_yumi_o,
    output logic [width_p-1:0]                     disp_data_o,
    output logic [$clog2(num_results_p+1)-1:0]     disp_idx_o,
    output logic [1:0]                             state_o,
    output logic [$clog2(num_entries_p+1)-1:0]     entry_count_o
);

    localparam int bit_w   = $clog2(width_p+1);
    localparam int ent_w   = $clog2(num_entries_p+1);
    localparam int res_w   = $clog2(num_results_p+1);
    localparam int dwell_w = $clog2(dwell_cycles_p+1);
    localparam int idx_w   = (num_results_p > 1) ? $clog2(num_results_p) : 1;

    localparam logic [bit_w-1:0]   bit_last   = bit_w'(width_p-1);
    localparam logic [ent_w-1:0]   ent_last   = ent_w'(num_entries_p-1);
    localparam logic [res_w-1:0]   res_last   = res_w'(num_results_p-1);
    localparam logic [dwell_w-1:0] dwell_last = dwell_w'(dwell_cycles_p-1);

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_OFFER   = 2'd1,
        ST_COLLECT = 2'd2,
        ST_SHOW    = 2'd3
    } state_t;

    state_t               state;
    logic [width_p-1:0]   sr;
    logic [width_p-1:0]   sr_next;
    logic [bit_w-1:0]     bit_cnt;
    logic [width_p-1:0]   op_data;
    logic [ent_w-1:0]     entry_count;
    logic [res_w-1:0]     res_cnt;
    logic [res_w-1:0]     disp_idx;
    logic [dwell_w-1:0]   dwell_cnt;
    logic [width_p-1:0]   res_buf [num_results_p];

    // MSB-first: each new bit enters at the LSB end
    assign sr_next = (sr << 1) | width_p'(bit_i);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= ST_ENTRY;
            sr          <= '0;
            bit_cnt     <= '0;
            op_data     <= '0;
            entry_count <= '0;
            res_cnt     <= '0;
            disp_idx    <= '0;
            dwell_cnt   <= '0;
            for (int i = 0; i < num_results_p; i++) res_buf[i] <= '0;
        end else begin
            case (state)
                ST_ENTRY: begin
                    if (bit_valid_i) begin
                        sr <= sr_next;
                        if (bit_cnt == bit_last) begin
                            op_data <= sr_next;
                            bit_cnt <= '0;
                            state   <= ST_OFFER;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_OFFER: begin
                    if (op_ready_i) begin
                        entry_count <= entry_count + 1'b1;
                        sr          <= '0;
                        state       <= (entry_count == ent_last) ? ST_COLLECT : ST_ENTRY;
                    end
                end
                ST_COLLECT: begin
                    if (res_valid_i) begin
                        res_buf[res_cnt[idx_w-1:0]] <= res_data_i;
                        res_cnt <= res_cnt + 1'b1;
                        if (res_cnt == res_last) begin
                            disp_idx  <= '0;
                            dwell_cnt <= '0;
                            state     <= ST_SHOW;
                        end
                    end
                end
                ST_SHOW: begin
                    if (dwell_cnt == dwell_last) begin
                        dwell_cnt <= '0;
                        if (disp_idx == res_last) begin
                            entry_count <= '0;
                            res_cnt     <= '0;
                            disp_idx    <= '0;
                            state       <= ST_ENTRY;
                        end else begin
                            disp_idx <= disp_idx + 1'b1;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                default: state <= ST_ENTRY;
            endcase
        end
    end

    assign op_valid_o    = (state == ST_OFFER);
    assign op_data_o     = op_data;
    assign res_yumi_o    = (state == ST_COLLECT) & res_valid_i;
    assign disp_idx_o    = disp_idx;
    assign state_o       = state;
    assign entry_count_o = entry_count;

    always_comb begin
        disp_data_o = '0;
        case (state)
            ST_ENTRY:   disp_data_o = sr;
            ST_OFFER:   disp_data_o = op_data;
            ST_COLLECT: disp_data_o = '0;
            ST_SHOW:    disp_data_o = res_buf[disp_idx[idx_w-1:0]];
            default:    disp_data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_matrix_io_seq.sv
// Scoreboard bench for matrix_io_seq: a full-size job (dwell 3) on one instance
// and a 4-bit single-entry/single-result configuration on a second.
module tb_matrix_io_seq;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk = ~clk;

    // Instance A: width 8, 4 entries, 4 results, dwell 3
    logic       a_bit_valid = 0, a_bit = 0, a_op_ready = 0, a_res_valid = 0;
    logic [7:0] a_res_data = 0;
    logic       a_op_valid, a_res_yumi;
    logic [7:0] a_op_data, a_disp;
    logic [2:0] a_idx, a_entry;
    logic [1:0] a_state;

    matrix_io_seq #(.width_p(8), .num_entries_p(4), .num_results_p(4), .dwell_cycles_p(3)) u_a (
        .clk_i(clk), .reset_i(reset_i),
        .bit_valid_i(a_bit_valid), .bit_i(a_bit),
        .op_valid_o(a_op_valid), .op_data_o(a_op_data), .op_ready_i(a_op_ready),
        .res_valid_i(a_res_valid), .res_data_i(a_res_data), .res_yumi_o(a_res_yumi),
        .disp_data_o(a_disp), .disp_idx_o(a_idx), .state_o(a_state), .entry_count_o(a_entry)
    );

    // Instance B: width 4, 1 entry, 1 result, dwell 2
    logic       b_bit_valid = 0, b_bit = 0, b_op_ready = 0, b_res_valid = 0;
    logic [3:0] b_res_data = 0;
    logic       b_op_valid, b_res_yumi;
    logic [3:0] b_op_data, b_disp;
    logic [0:0] b_idx, b_entry;
    logic [1:0] b_state;

    matrix_io_seq #(.width_p(4), .num_entries_p(1), .num_results_p(1), .dwell_cycles_p(2)) u_b (
        .clk_i(clk), .reset_i(reset_i),
        .bit_valid_i(b_bit_valid), .bit_i(b_bit),
        .op_valid_o(b_op_valid), .op_data_o(b_op_data), .op_ready_i(b_op_ready),
        .res_valid_i(b_res_valid), .res_data_i(b_res_data), .res_yumi_o(b_res_yumi),
        .disp_data_o(b_disp), .disp_idx_o(b_idx), .state_o(b_state), .entry_count_o(b_entry)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] op_q[$];
    logic [7:0] disp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Operand scoreboard: every handshake must match the next queued word
    always @(negedge clk) begin
        if (!reset_i && a_op_valid && a_op_ready) begin
            chk("op_expected", (op_q.size() != 0), 1);
            if (op_q.size() != 0) begin
                chk("op_word", a_op_data, op_q[0]);
                op_q.delete(0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_state"}, a_state, 0);
        chk({tag, "_opv"},   a_op_valid, 0);
        chk({tag, "_opd"},   a_op_data, 0);
        chk({tag, "_disp"},  a_disp, 0);
        chk({tag, "_idx"},   a_idx, 0);
        chk({tag, "_entry"}, a_entry, 0);
        chk({tag, "_yumi"},  a_res_yumi, 0);
    endtask

    task automatic send_word(input logic [7:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            a_bit_valid = 1'b1;
            a_bit = w[i];
            step();
        end
        a_bit_valid = 1'b0;
        a_bit = 1'b0;
    endtask

    task automatic wait_accept();
        for (int i = 0; i < 8 && a_op_valid; i++) step();
        chk("accept_timeout", a_op_valid, 0);
    endtask

    task automatic give_res(input logic v, input logic [7:0] d);
        a_res_valid = v;
        a_res_data = d;
        #1;
        chk("yumi", a_res_yumi, v);
        step();
        a_res_valid = 1'b0;
        a_res_data = '0;
    endtask

    task automatic run_job(input logic [7:0] base);
        a_op_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            op_q.push_back(base + 8'(k));
            send_word(base + 8'(k), 8);
            wait_accept();
        end
        a_op_ready = 1'b0;
        chk("job_entry", a_entry, 4);
        chk("job_state", a_state, 2);
        chk("job_q_empty", op_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] bw;
        step();
        step();
        reset_i = 1'b0;
        check_zero("rst");

        // Partial word visible, then discarded by reset
        send_word(8'h14, 5);
        chk("partial_disp", a_disp, 8'h14);
        do_reset();
        check_zero("rst_word");

        // Word assembly with ready low, extra pulses dropped in OFFER
        send_word(8'hA5, 8);
        chk("asm_valid", a_op_valid, 1);
        chk("asm_data",  a_op_data, 8'hA5);
        chk("asm_state", a_state, 1);
        a_bit_valid = 1'b1;
        a_bit = 1'b1;
        repeat (3) step();
        a_bit_valid = 1'b0;
        chk("offer_hold", a_op_data, 8'hA5);
        chk("offer_disp", a_disp, 8'hA5);
        chk("offer_valid", a_op_valid, 1);
        do_reset();
        check_zero("rst_offer");

        // Entry count through 4 handshakes
        run_job(8'h01);
        chk("collect_disp", a_disp, 0);

        // Collect with a gap, then show sequence
        give_res(1, 8'h11);
        give_res(1, 8'h22);
        give_res(0, 8'h00);
        give_res(1, 8'h33);
        foreach (disp_q[i]) disp_q.delete(i);
        for (int v = 1; v <= 4; v++) repeat (3) disp_q.push_back(8'(v * 8'h11));
        give_res(1, 8'h44);
        chk("show_state", a_state, 3);
        for (int i = 0; i < 12; i++) begin
            chk("show_disp", a_disp, disp_q.pop_front());
            chk("show_idx", a_idx, i / 3);
            a_bit_valid = (i % 4 == 1);
            a_bit = 1'b1;
            step();
        end
        a_bit_valid = 1'b0;
        a_bit = 1'b0;
        chk("end_state", a_state, 0);
        chk("end_entry", a_entry, 0);
        chk("end_disp",  a_disp, 0);

        // Second job, reset during SHOW at index 2
        run_job(8'h05);
        give_res(1, 8'h55);
        give_res(1, 8'h66);
        give_res(1, 8'h77);
        give_res(1, 8'h88);
        repeat (6) step();
        chk("mid_idx",  a_idx, 2);
        chk("mid_disp", a_disp, 8'h77);
        do_reset();
        check_zero("rst_show");
        send_word(8'hA5, 8);
        chk("fresh_data", a_op_data, 8'hA5);
        chk("fresh_valid", a_op_valid, 1);

        // Parameter sweep instance
        bw = 4'hC;
        for (int i = 3; i >= 0; i--) begin
            b_bit_valid = 1'b1;
            b_bit = bw[i];
            step();
        end
        b_bit_valid = 1'b0;
        b_bit = 1'b0;
        chk("b_data",  b_op_data, 4'hC);
        chk("b_state_offer", b_state, 1);
        b_op_ready = 1'b1;
        step();
        b_op_ready = 1'b0;
        chk("b_state_collect", b_state, 2);
        chk("b_entry", b_entry, 1);
        b_res_valid = 1'b1;
        b_res_data = 4'h9;
        #1;
        chk("b_yumi", b_res_yumi, 1);
        step();
        b_res_valid = 1'b0;
        chk("b_state_show", b_state, 3);
        repeat (2) begin
            chk("b_disp", b_disp, 4'h9);
            step();
        end
        chk("b_state_end", b_state, 0);
        chk("b_entry_end", b_entry, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
